// File: rtl/scarv_soc_bram_arbiter_if.sv
// Bundle between the two bus requesters, the arbiter and BRAM port A.
// Slave modport is the arbiter's view; master is the requester/BRAM side.
interface scarv_soc_bram_arbiter_if #(
   parameter int LW = 10
);
   logic          r0_req;
   logic          r0_gnt;
   logic          r0_wen;
   logic [3:0]    r0_strb;
   logic [31:0]   r0_addr;
   logic [31:0]   r0_wdata;
   logic          r0_rsp;
   logic          r0_rsp_err;
   logic [31:0]   r0_rdata;

   logic          r1_req;
   logic          r1_gnt;
   logic          r1_wen;
   logic [3:0]    r1_strb;
   logic [31:0]   r1_addr;
   logic [31:0]   r1_wdata;
   logic          r1_rsp;
   logic          r1_rsp_err;
   logic [31:0]   r1_rdata;

   logic          ena;
   logic [3:0]    wea;
   logic [LW-1:0] addra;
   logic [31:0]   dina;
   logic [31:0]   douta;

   modport slave (
      input  r0_req, r0_wen, r0_strb, r0_addr, r0_wdata,
      output r0_gnt, r0_rsp, r0_rsp_err, r0_rdata,
      input  r1_req, r1_wen, r1_strb, r1_addr, r1_wdata,
      output r1_gnt, r1_rsp, r1_rsp_err, r1_rdata,
      output ena, wea, addra, dina,
      input  douta
   );

   modport master (
      output r0_req, r0_wen, r0_strb, r0_addr, r0_wdata,
      input  r0_gnt, r0_rsp, r0_rsp_err, r0_rdata,
      output r1_req, r1_wen, r1_strb, r1_addr, r1_wdata,
      input  r1_gnt, r1_rsp, r1_rsp_err, r1_rdata,
      input  ena, wea, addra, dina,
      output douta
   );
endinterface

// File: rtl/scarv_soc_bram_arbiter.sv
// Two-requester arbiter for BRAM port A; SCARV_SOC_BRAM_ARB_RR_EN selects round-robin, else R0 priority.
// Grant is combinational, response exactly 1 cycle later; no response backpressure, 1 grant/cycle.
module scarv_soc_bram_arbiter #(
   parameter int DEPTH    = 1024,
   parameter bit WRITE_EN = 1'b1
) (
   input  logic                    clka,
   input  logic                    rsta,
   scarv_soc_bram_arbiter_if.slave bus
);
   localparam int LW = $clog2(DEPTH);

   logic        r_rsp_pend;
   logic        r_rsp_err;
   logic        r_last;

   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_any;
   logic        w_wen;
   logic        w_fault;
   logic [3:0]  w_strb;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!rsta) begin
`ifdef SCARV_SOC_BRAM_ARB_RR_EN
         if (bus.r0_req && bus.r1_req) begin
            w_gnt0 = r_last;
            w_gnt1 = ~r_last;
         end else begin
            w_gnt0 = bus.r0_req;
            w_gnt1 = bus.r1_req;
         end
`else
         w_gnt0 = bus.r0_req;
         w_gnt1 = bus.r1_req & ~bus.r0_req;
`endif
      end
   end

   assign w_any   = w_gnt0 | w_gnt1;
   assign w_wen   = w_gnt1 ? bus.r1_wen   : bus.r0_wen;
   assign w_strb  = w_gnt1 ? bus.r1_strb  : bus.r0_strb;
   assign w_addr  = w_gnt1 ? bus.r1_addr  : bus.r0_addr;
   assign w_wdata = w_gnt1 ? bus.r1_wdata : bus.r0_wdata;

   // Faulting accesses are still granted but never reach the BRAM.
   assign w_fault = (w_addr >= 32'(DEPTH)) || (w_wen && !WRITE_EN);

   always_comb begin
      bus.ena   = 1'b0;
      bus.wea   = 4'b0000;
      bus.addra = w_addr[LW-1:0];
      bus.dina  = w_wdata;
      if (w_any && !w_fault) begin
         bus.ena = 1'b1;
         bus.wea = w_wen ? w_strb : 4'b0000;
      end
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         r_rsp_pend <= 1'b0;
         r_rsp_err  <= 1'b0;
         r_last     <= 1'b1;
      end else begin
         r_rsp_pend <= w_any;
         if (w_any) begin
            r_rsp_err <= w_fault;
            r_last    <= w_gnt1;
         end
      end
   end

   // r_last always holds the most recent grantee, so it doubles as the response owner.
   assign bus.r0_gnt     = w_gnt0;
   assign bus.r1_gnt     = w_gnt1;
   assign bus.r0_rsp     = r_rsp_pend & ~r_last;
   assign bus.r1_rsp     = r_rsp_pend &  r_last;
   assign bus.r0_rsp_err = r_rsp_pend & ~r_last & r_rsp_err;
   assign bus.r1_rsp_err = r_rsp_pend &  r_last & r_rsp_err;
   assign bus.r0_rdata   = bus.douta;
   assign bus.r1_rdata   = bus.douta;
endmodule
